// File: rtl/regressive_step_counter.sv
// regressive_step_counter
//   Timed down-counter. A rising edge on init_signal loads load_val. The value
//   then steps down by one every TICK_DIV unheld clock cycles until it has
//   shown 0 for a full period. At that point final_signal pulses for one cycle
//   back to the top-level FSM. resta drives the seven-segment printer during
//   the countdown states.
//
//   Optional feature macro: REGRESSIVE_AUTO_RELOAD_EN
//     When defined, the counter reloads the latched start value instead of
//     finishing, pulses final_signal once per lap, and stays busy until it is
//     aborted or reset. The DONE state is not used in that build.
//     When undefined (the default), the counter runs single-shot.
//
//   Parameter constraint: 2**TDW must be greater than TICK_DIV, and TICK_DIV
//   must be at least 2.
module regressive_step_counter #(
    parameter int WIDTH    = 4,
    parameter int TICK_DIV = 25000000,
    parameter int TDW      = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init_signal,
    input  logic [WIDTH-1:0] load_val,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] resta,
    output logic             final_signal,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [TDW-1:0]   PRE_LAST = TDW'(TICK_DIV - 1);
    localparam logic [TDW-1:0]   PRE_ONE  = TDW'(1);
    localparam logic [WIDTH-1:0] VAL_ONE  = WIDTH'(1);

    state_t         state;
    logic [TDW-1:0] prescaler;
    logic           init_q;
    logic           start;
    logic           at_last;

`ifdef REGRESSIVE_AUTO_RELOAD_EN
    // Start value kept for reloading at the end of every lap.
    logic [WIDTH-1:0] load_reg;
`endif

    // A start is a 0->1 transition only, so a held-high request never
    // retriggers the counter.
    assign start   = init_signal & ~init_q;
    assign at_last = (prescaler == PRE_LAST);

    // Delay init_signal by one cycle for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register sees pre-edge values regardless of statement order.
            init_q <= init_signal;
        end
    end

    // Control FSM with the prescaler, the count value and the registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prescaler    <= '0;
            resta        <= '0;
            final_signal <= 1'b0;
            busy         <= 1'b0;
`ifdef REGRESSIVE_AUTO_RELOAD_EN
            load_reg     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // resta keeps showing the last value until the next start.
                    final_signal <= 1'b0;
                    busy         <= 1'b0;
                    if (start) begin
                        resta     <= load_val;
`ifdef REGRESSIVE_AUTO_RELOAD_EN
                        load_reg  <= load_val;
`endif
                        prescaler <= '0;
                        busy      <= 1'b1;
                        state     <= COUNT;
                    end
                end

                COUNT: begin
                    // The completion pulse lasts one cycle. This also clears a
                    // pulse raised in the previous cycle of an auto-reload lap.
                    final_signal <= 1'b0;
                    if (abort) begin
                        // abort beats hold and tick. resta keeps its value and
                        // no completion pulse is raised.
                        prescaler <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (!hold) begin
                        if (at_last) begin
                            prescaler <= '0;
                            if (resta != '0) begin
                                resta <= resta - VAL_ONE;
                            end else begin
                                final_signal <= 1'b1;
`ifdef REGRESSIVE_AUTO_RELOAD_EN
                                resta        <= load_reg;
`else
                                busy         <= 1'b0;
                                state        <= DONE;
`endif
                            end
                        end else begin
                            prescaler <= prescaler + PRE_ONE;
                        end
                    end
                end

                DONE: begin
                    // Single-cycle completion state. A start edge seen here is
                    // dropped because IDLE only looks at the current edge.
                    final_signal <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    final_signal <= 1'b0;
                    busy         <= 1'b0;
                    prescaler    <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regressive_step_counter.sv
// tb_regressive_step_counter
//   Self-checking bench for regressive_step_counter with TICK_DIV=4.
//   The reference model describes a run by the number of unheld cycles since
//   the start. The expected value is load - elapsed/TICK_DIV, and completion
//   comes at (load+1)*TICK_DIV unheld cycles. Directed scenarios pin the exact
//   timings with literal values. A randomized phase follows them.
//   Compile with +define+REGRESSIVE_AUTO_RELOAD_EN to check the reload build.
module tb_regressive_step_counter;

    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int TDW      = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             init_signal;
    logic [WIDTH-1:0] load_val;
    logic             hold;
    logic             abort;
    logic [WIDTH-1:0] resta;
    logic             final_signal;
    logic             busy;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Behavioural reference model state.
    typedef enum {M_IDLE, M_RUN, M_DONE} phase_t;
    phase_t m_phase;
    bit     m_init_q;
    int     m_load;
    int     m_unheld;
    int     m_resta;
    bit     m_final;
    bit     m_busy;

    always #5 clk = ~clk;

    regressive_step_counter #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV),
        .TDW      (TDW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .init_signal  (init_signal),
        .load_val     (load_val),
        .hold         (hold),
        .abort        (abort),
        .resta        (resta),
        .final_signal (final_signal),
        .busy         (busy)
    );

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase  = M_IDLE;
        m_init_q = 1'b0;
        m_load   = 0;
        m_unheld = 0;
        m_resta  = 0;
        m_final  = 1'b0;
        m_busy   = 1'b0;
    endfunction

    // Advance the model by one clock edge, using the inputs the DUT sampled.
    function automatic void model_step();
        bit start;
        int period;
        start    = init_signal && !m_init_q;
        m_init_q = init_signal;
        case (m_phase)
            M_IDLE: begin
                m_final = 1'b0;
                m_busy  = 1'b0;
                if (start) begin
                    m_phase  = M_RUN;
                    m_load   = int'(load_val);
                    m_unheld = 0;
                    m_resta  = m_load;
                    m_busy   = 1'b1;
                end
            end
            M_RUN: begin
                m_final = 1'b0;
                if (abort) begin
                    m_phase = M_IDLE;
                    m_busy  = 1'b0;
                end else if (!hold) begin
                    m_unheld++;
                    period = (m_load + 1) * TICK_DIV;
`ifdef REGRESSIVE_AUTO_RELOAD_EN
                    m_final = ((m_unheld % period) == 0);
                    m_resta = m_load - (m_unheld % period) / TICK_DIV;
`else
                    if (m_unheld == period) begin
                        m_phase = M_DONE;
                        m_final = 1'b1;
                        m_busy  = 1'b0;
                        m_resta = 0;
                    end else begin
                        m_resta = m_load - m_unheld / TICK_DIV;
                    end
`endif
                end
            end
            default: begin
                m_final = 1'b0;
                m_busy  = 1'b0;
                m_phase = M_IDLE;
            end
        endcase
    endfunction

    // Compare the DUT against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("model_resta", int'(resta), m_resta);
            check("model_final", int'(final_signal), int'(m_final));
            check("model_busy", int'(busy), int'(m_busy));
        end
    end

    // One clock: the DUT and the model both advance on the rising edge.
    task automatic tick_cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    // Advance until final_signal is seen, with at least one cycle per call.
    task automatic wait_final(input int budget, output int n);
        n = 0;
        do begin
            tick_cycle();
            n++;
        end while (!final_signal && n < budget);
        if (!final_signal) check("final_timeout", 0, 1);
    endtask

    // Raise init_signal for one cycle. On return the DUT has entered COUNT.
    task automatic start_run(input logic [WIDTH-1:0] v);
        load_val    = v;
        init_signal = 1'b1;
        tick_cycle();
        init_signal = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        init_signal = 1'b0;
        load_val    = '0;
        hold        = 1'b0;
        abort       = 1'b0;
        model_reset();
        #2;
        check("reset_resta", int'(resta), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_final", int'(final_signal), 0);
        @(negedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;
        run_cycles(2);

`ifndef REGRESSIVE_AUTO_RELOAD_EN
        // Basic countdown: 3,2,1,0 each for 4 cycles; pulse 16 cycles after entry.
        start_run(4'd3);
        check("basic_first_value", int'(resta), 3);
        check("basic_busy", int'(busy), 1);
        run_cycles(4);
        check("basic_second_value", int'(resta), 2);
        wait_final(100, n);
        check("basic_final_after_entry", n + 4, 16);
        check("basic_busy_at_final", int'(busy), 0);
        tick_cycle();
        check("basic_final_one_cycle", int'(final_signal), 0);
        run_cycles(2);

        // Zero load with init held high, then drop and re-raise.
        load_val    = 4'd0;
        init_signal = 1'b1;
        tick_cycle();
        wait_final(100, n);
        check("zero_final_after", n, 4);
        run_cycles(20);
        check("held_init_no_retrigger", int'(busy), 0);
        init_signal = 1'b0;
        tick_cycle();
        load_val    = 4'd1;
        init_signal = 1'b1;
        tick_cycle();
        check("retrigger_busy", int'(busy), 1);
        check("retrigger_value", int'(resta), 1);
        wait_final(100, n);
        check("retrigger_final_after", n, 8);
        init_signal = 1'b0;
        run_cycles(2);

        // Hold and ignored start edge.
        start_run(4'd2);
        run_cycles(2);
        load_val    = 4'd9;
        init_signal = 1'b1;
        tick_cycle();
        init_signal = 1'b0;
        check("ignored_start_value", int'(resta), 2);
        run_cycles(2);
        check("hold_pre_value", int'(resta), 1);
        hold = 1'b1;
        run_cycles(10);
        check("hold_frozen_value", int'(resta), 1);
        hold = 1'b0;
        wait_final(100, n);
        check("hold_total_delay", 5 + 10 + n, 22);
        run_cycles(2);

        // Abort at resta=6, then a normal run.
        start_run(4'd9);
        run_cycles(13);
        check("abort_pre_value", int'(resta), 6);
        abort = 1'b1;
        tick_cycle();
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_keeps_value", int'(resta), 6);
        run_cycles(30);
        start_run(4'd2);
        wait_final(100, n);
        check("after_abort_final", n, 12);
        run_cycles(2);
`else
        // Auto-reload: 1,0,1,0,... with a pulse every 8 cycles, ended by abort.
        start_run(4'd1);
        wait_final(100, n);
        check("reload_first_final", n, 8);
        check("reload_busy", int'(busy), 1);
        check("reload_value", int'(resta), 1);
        wait_final(100, n);
        check("reload_second_final", n, 8);
        abort = 1'b1;
        tick_cycle();
        abort = 1'b0;
        check("reload_abort_busy", int'(busy), 0);
        run_cycles(20);
`endif

        // Asynchronous reset in the middle of COUNT, with resta=5.
        start_run(4'd7);
        run_cycles(9);
        check("reset_pre_value", int'(resta), 5);
        #2 reset = 1'b1;
        #1;
        check("async_reset_resta", int'(resta), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_final", int'(final_signal), 0);
        model_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        run_cycles(3);
        check("post_reset_idle", int'(busy), 0);

        // Randomized traffic, checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            load_val = WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) init_signal = ~init_signal;
            hold  = ($urandom_range(0, 3) == 0);
            abort = ($urandom_range(0, 39) == 0);
            tick_cycle();
        end
        hold        = 1'b0;
        abort       = 1'b0;
        init_signal = 1'b0;
        run_cycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regressive_step_counter.md
Name: regressive_step_counter

Overview:
- Timed down-counter; the counting-down counterpart of the progressive counter.
- On a start request it loads a 4-bit value and decrements it once per prescaled period until it reaches 0.
- It then pulses a completion flag back to the top-level FSM.
- Its value output feeds the seven-segment printer in the countdown states.

Parameters:
WIDTH, 4, width of count value and load value
TICK_DIV, 25000000, clk cycles per count step (>=2); benches use 4
TDW, 25, prescaler register width; must satisfy 2^TDW > TICK_DIV

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
init_signal  in  1  start request, level; a 0->1 transition is detected internally
load_val  in  WIDTH  start value, sampled on the accepted start cycle
hold  in  1  pause: freezes prescaler and value while high
abort  in  1  synchronous cancel back to IDLE, no completion pulse
resta  out  WIDTH  current count value (registered)
final_signal  out  1  one-cycle completion pulse
busy  out  1  high in COUNT state

Behaviour:
- Reset values: state=IDLE, resta=0, final_signal=0, busy=0, prescaler=0, edge register init_q=0.
- Start edge: start = init_signal & ~init_q, where init_q is init_signal delayed one clk.
  - Only edges are accepted; a held-high init_signal never retriggers.
- States: IDLE, COUNT, DONE.
- IDLE:
  - resta holds its last value; final_signal=0.
  - On start: resta<=load_val, load_reg<=load_val, prescaler<=0, go to COUNT.
  - busy is 1 from the next cycle.
- COUNT:
  - busy=1. If hold=1, prescaler and resta freeze.
  - Otherwise the prescaler increments; at prescaler==TICK_DIV-1 it wraps to 0 and a step tick occurs that cycle.
  - On tick with resta!=0: resta<=resta-1.
  - On tick with resta==0: go to DONE; resta stays 0.
  - Each value load_val..0 is therefore visible for exactly TICK_DIV unheld cycles; total = (load_val+1)*TICK_DIV cycles.
  - load_val=0: 0 is shown for one period, then DONE.
- DONE:
  - final_signal=1 for exactly this one cycle, busy=0, then unconditionally to IDLE.
  - A start edge arriving in DONE is ignored; a new start must come after returning to IDLE.
- Start edges during COUNT are ignored; no restart or reload.
- abort:
  - Has priority over hold and tick in COUNT: go to IDLE next cycle, prescaler<=0, final_signal stays 0, resta keeps its current value.
  - Ignored in IDLE and DONE.
- Simultaneous hold and tick: hold wins, so no tick occurs.
- Arithmetic: unsigned WIDTH bits. Underflow below 0 is impossible in the base build.
- Reset mid-operation: all outputs return to reset values asynchronously; a final_signal in flight is cancelled.

Optional Feature:
REGRESSIVE_AUTO_RELOAD_EN
- Defined: a tick with resta==0 in COUNT pulses final_signal for one cycle and reloads resta<=load_reg.
  - The block remains in COUNT with busy=1, repeating indefinitely; only abort or reset exit.
  - DONE is unused.
- Not defined: the base single-shot behaviour above, and load_reg may be omitted.

Test Plan (TICK_DIV=4):
- Reset check: assert reset mid-COUNT with resta=5 -> resta=0, busy=0, final_signal=0 within the same cycle with no clk edge; state IDLE after release.
- Basic countdown: load_val=3, init_signal 0->1 -> resta sequence 3,2,1,0, each held 4 cycles; final_signal high exactly 1 cycle, 16 cycles after COUNT entry; busy low from then.
- Zero load and retrigger: load_val=0 start -> final_signal after 4 cycles. init_signal held high throughout -> no second run. Drop and re-raise -> second run starts.
- Hold and ignore: load_val=2 run, hold high 10 cycles while resta=1 -> resta stays 1 and completion is delayed by exactly 10 cycles. A start edge during COUNT changes nothing.
- Abort: load_val=9, abort at resta=6 -> IDLE next cycle, resta=6, no final_signal pulse; a later start with load_val=2 runs normally.
- Auto-reload (macro defined): load_val=1 -> resta 1,0,1,0,...; final_signal pulses every 8 cycles and busy stays 1; abort ends the run.
